// File: rtl/ras_pkg.sv
// ============================================================================
// Module      : ras_pkg
// Description : Shared defaults, null return address and FSM encoding for the
//               return-address-stack manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ras_pkg;

  localparam int unsigned RAS_XLEN  = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam logic [31:0] RAS_NULL  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_POP     = 2'd1,
    RD_POPPUSH = 2'd2
  } ras_state_e;

endpackage

`default_nettype wire

// File: rtl/ras_mem.sv
// ============================================================================
// Module      : ras_mem
// Description : DEPTH x XLEN single-port storage, one read or write per cycle,
//               synchronous read with the read data held until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_mem
  import ras_pkg::*;
#(
  parameter int unsigned XLEN  = RAS_XLEN,
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ras_manager.sv
// ============================================================================
// Module      : ras_manager
// Description : Circular return-address stack with push/pop/pop-then-push
//               requests, flush, overflow reporting and 1-cycle pop latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_manager
  import ras_pkg::*;
#(
  parameter int unsigned XLEN  = RAS_XLEN,
  parameter int unsigned DEPTH = RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] pctoras,
  input  logic            flush,
  output logic [XLEN-1:0] pcfromras,
  output logic            pop_valid,
  output logic            pop_miss,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int unsigned     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     COUNT_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     COUNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0]   SP_ONE    = AW'(1);
  localparam logic [XLEN-1:0] NULL_ADDR = XLEN'(RAS_NULL);

  ras_state_e      state_q, state_d;
  logic [AW-1:0]   sp_q, sp_d;
  logic [AW:0]     count_q, count_d;
  logic            miss_q, miss_d;
  logic [XLEN-1:0] push_data_q, push_data_d;
  logic            overflow_q, overflow_d;
  logic [XLEN-1:0] pcfromras_q, pcfromras_d;

  logic            accept;
  logic [XLEN-1:0] pop_data;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  ras_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .en_i    (mem_en && !reset_in),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    count_d     = count_q;
    miss_d      = miss_q;
    push_data_d = push_data_q;
    overflow_d  = 1'b0;
    pcfromras_d = pcfromras_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = sp_q;
    mem_wdata   = pctoras;

    req_ready = (state_q == IDLE) && !reset_in;
    accept    = req_valid && req_ready;

    // The pop result leaves combinationally in the read cycle; flush or reset
    // arriving in that same cycle cancels it.
    pop_valid = (state_q != IDLE) && !flush && !reset_in;
    pop_miss  = pop_valid && miss_q;
    pop_data  = miss_q ? NULL_ADDR : mem_rdata;
    pcfromras = pop_valid ? pop_data : pcfromras_q;
    if (pop_valid) begin
      pcfromras_d = pop_data;
    end

    if (flush) begin
      sp_d    = '0;
      count_d = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (pop) begin
              push_data_d = pctoras;
              state_d     = push ? RD_POPPUSH : RD_POP;
              if (count_q == '0) begin
                miss_d = 1'b1;
              end else begin
                miss_d   = 1'b0;
                mem_en   = 1'b1;
                mem_addr = sp_q - SP_ONE;
                sp_d     = sp_q - SP_ONE;
                count_d  = count_q - COUNT_ONE;
              end
            end else if (push) begin
              mem_en   = 1'b1;
              mem_we   = 1'b1;
              mem_addr = sp_q;
              sp_d     = sp_q + SP_ONE;
              if (count_q == COUNT_MAX) begin
                overflow_d = 1'b1;
              end else begin
                count_d = count_q + COUNT_ONE;
              end
            end
          end
        end

        RD_POP: begin
          state_d = IDLE;
        end

        RD_POPPUSH: begin
          // The read completed last cycle, so the port is free for the write.
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = sp_q;
          mem_wdata = push_data_q;
          sp_d      = sp_q + SP_ONE;
          count_d   = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + COUNT_ONE;
          state_d   = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      count_q     <= '0;
      miss_q      <= 1'b0;
      push_data_q <= '0;
      overflow_q  <= 1'b0;
      pcfromras_q <= NULL_ADDR;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      miss_q      <= miss_d;
      push_data_q <= push_data_d;
      overflow_q  <= overflow_d;
      pcfromras_q <= pcfromras_d;
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == COUNT_MAX);
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ras_manager.sv
// ============================================================================
// Module      : tb_ras_manager
// Description : Self-checking bench: queue-based stack model compared every
//               cycle, directed scenarios with literal expectations, then
//               randomized traffic with flush and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ras_manager;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] NULLA = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        req_valid;
  logic        req_ready;
  logic        push;
  logic        pop;
  logic [31:0] pctoras;
  logic        flush;
  logic [31:0] pcfromras;
  logic        pop_valid;
  logic        pop_miss;
  logic        empty;
  logic        full;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ras_manager #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .push      (push),
    .pop       (pop),
    .pctoras   (pctoras),
    .flush     (flush),
    .pcfromras (pcfromras),
    .pop_valid (pop_valid),
    .pop_miss  (pop_miss),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stack kept as a queue, newest at the back; the oldest entry drops off the
  // front when a push exceeds DEPTH.
  logic [31:0] stk[$];
  int          pend = 0;          // 0 none, 1 pop result due, 2 pop result + push due
  logic        pend_miss = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] pend_push = '0;
  logic [31:0] pc_hold = NULLA;
  logic        exp_ovf = 1'b0;
  logic        check_on = 1'b0;

  function automatic void m_push(input logic [31:0] a);
    stk.push_back(a);
    if (stk.size() > DEPTH) begin
      void'(stk.pop_front());
      exp_ovf = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    exp_ovf = 1'b0;
    if (reset_in) begin
      stk.delete();
      pend    = 0;
      pc_hold = NULLA;
    end else if (flush) begin
      stk.delete();
      pend = 0;
    end else if (pend != 0) begin
      pc_hold = pend_miss ? NULLA : pend_data;
      if (pend == 2) m_push(pend_push);
      pend = 0;
    end else if (req_valid) begin
      if (pop) begin
        pend_push = pctoras;
        pend      = push ? 2 : 1;
        if (stk.size() == 0) begin
          pend_miss = 1'b1;
        end else begin
          pend_miss = 1'b0;
          pend_data = stk.pop_back();
        end
      end else if (push) begin
        m_push(pctoras);
      end
    end
  end

  logic ev_exp;
  always @(negedge clk) begin
    if (check_on) begin
      ev_exp = (pend != 0) && !flush && !reset_in;
      chk("req_ready", 32'(req_ready), 32'((pend == 0) && !reset_in));
      chk("pop_valid", 32'(pop_valid), 32'(ev_exp));
      chk("pop_miss", 32'(pop_miss), 32'(ev_exp && pend_miss));
      chk("pcfromras", pcfromras, ev_exp ? (pend_miss ? NULLA : pend_data) : pc_hold);
      chk("empty", 32'(empty), 32'(stk.size() == 0));
      chk("full", 32'(full), 32'(stk.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] a);
    req_valid = 1'b1; push = 1'b1; pop = 1'b0; pctoras = a;
    cyc();
    idle_in();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] addr, input logic miss);
    req_valid = 1'b1; pop = 1'b1; push = 1'b0;
    cyc();
    idle_in();
    @(negedge clk);
    chk({tag, "_valid"}, 32'(pop_valid), 32'd1);
    chk({tag, "_miss"}, 32'(pop_miss), 32'(miss));
    chk({tag, "_pc"}, pcfromras, addr);
    cyc();
  endtask

  initial begin
    reset_in = 1'b1;
    pctoras  = '0;
    idle_in();
    cyc();
    check_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_pc", pcfromras, NULLA);
    cyc();
    reset_in = 1'b0;
    cyc();

    // pop on empty after reset
    pop_expect("empty_pop", NULLA, 1'b1);
    @(negedge clk);
    chk("empty_pop_stays_empty", 32'(empty), 32'd1);
    cyc();

    // LIFO order
    do_push(32'h100);
    do_push(32'h200);
    do_push(32'h300);
    pop_expect("lifo0", 32'h300, 1'b0);
    pop_expect("lifo1", 32'h200, 1'b0);
    pop_expect("lifo2", 32'h100, 1'b0);
    @(negedge clk);
    chk("lifo_empty", 32'(empty), 32'd1);
    cyc();

    // overflow with 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) begin
      do_push(32'(i * 16));
      if (i == 8) begin
        @(negedge clk);
        chk("full_at8", 32'(full), 32'd1);
        chk("no_ovf_at8", 32'(overflow), 32'd0);
        cyc();
      end
    end
    @(negedge clk);
    chk("ovf_at9", 32'(overflow), 32'd1);
    cyc();
    for (int i = 9; i >= 2; i--) pop_expect("ovf_pop", 32'(i * 16), 1'b0);
    pop_expect("ovf_pop9_miss", NULLA, 1'b1);

    // pop-then-push
    do_push(32'h400);
    req_valid = 1'b1; pop = 1'b1; push = 1'b1; pctoras = 32'h500;
    cyc();
    idle_in();
    @(negedge clk);
    chk("pp_valid", 32'(pop_valid), 32'd1);
    chk("pp_pc", pcfromras, 32'h400);
    chk("pp_ready_low", 32'(req_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("pp_ready_back", 32'(req_ready), 32'd1);
    chk("pp_count", 32'(empty), 32'd0);
    cyc();
    pop_expect("pp_next", 32'h500, 1'b0);

    // flush the cycle after a pop is accepted
    do_push(32'h700);
    req_valid = 1'b1; pop = 1'b1; push = 1'b0;
    cyc();
    idle_in();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_no_valid", 32'(pop_valid), 32'd0);
    cyc();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ready", 32'(req_ready), 32'd1);
    cyc();
    pop_expect("flush_pop_miss", NULLA, 1'b1);
    do_push(32'h11);
    pop_expect("flush_push_pop", 32'h11, 1'b0);

    // reset during pop-then-push
    do_push(32'h600);
    req_valid = 1'b1; pop = 1'b1; push = 1'b1; pctoras = 32'h601;
    cyc();
    idle_in();
    reset_in = 1'b1;
    @(negedge clk);
    chk("rstpp_no_valid", 32'(pop_valid), 32'd0);
    chk("rstpp_ready", 32'(req_ready), 32'd0);
    cyc();
    reset_in = 1'b0;
    @(negedge clk);
    chk("rstpp_empty", 32'(empty), 32'd1);
    chk("rstpp_pc", pcfromras, NULLA);
    chk("rstpp_valid", 32'(pop_valid), 32'd0);
    chk("rstpp_ovf", 32'(overflow), 32'd0);
    cyc();
    pop_expect("rstpp_pop_miss", NULLA, 1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset_in  = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      req_valid = ($urandom_range(0, 9) < 7);
      push      = ($urandom_range(0, 9) < 6);
      pop       = ($urandom_range(0, 9) < 5);
      pctoras   = $urandom();
      cyc();
    end
    reset_in = 1'b0;
    idle_in();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
